// File: rtl/nts_tx_buffer.sv
// -----------------------------------------------------------------------------
// nts_tx_buffer
//
// Single-packet transmit buffer on the outbound side of the NTS engine. The
// response builder writes one packet as 64-bit words; the buffer then offers
// that packet to the transmit dispatcher through a packet_available /
// fifo_empty / rd_en / rd_data / last-word data_valid / read_discard handshake.
//
// Ports:
//   i_clk                  clock, all logic on the rising edge
//   i_areset               synchronous active-high reset
//   i_clear                synchronous clear of packet state (same effect as reset)
//   o_busy                 packet being written or awaiting readout
//   o_error                sticky protocol / overflow error
//   i_write_en             write i_write_data to the next buffer word
//   i_write_data[63:0]     packet word, byte 0 in bits 63:56
//   i_write_last           current write is the final word of the packet
//   i_last_word_data_valid byte-valid mask of the final word, MSB = byte 0
//   o_packet_available     complete packet held for readout
//   i_packet_read_discard  reader is done, release the packet
//   o_data_valid[7:0]      latched last-word mask, 0 when no packet is held
//   o_fifo_empty           every word of the current packet has been read
//   i_fifo_rd_en           read request
//   o_fifo_rd_data[63:0]   read data, one cycle after an accepted read
// -----------------------------------------------------------------------------
module nts_tx_buffer #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic        i_clk,
    input  logic        i_areset,
    input  logic        i_clear,
    output logic        o_busy,
    output logic        o_error,
    input  logic        i_write_en,
    input  logic [63:0] i_write_data,
    input  logic        i_write_last,
    input  logic [7:0]  i_last_word_data_valid,
    output logic        o_packet_available,
    input  logic        i_packet_read_discard,
    output logic [7:0]  o_data_valid,
    output logic        o_fifo_empty,
    input  logic        i_fifo_rd_en,
    output logic [63:0] o_fifo_rd_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    // Pointer value meaning "every location has been written".
    localparam logic [ADDR_WIDTH:0] PTR_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] PTR_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] PTR_ZERO = '0;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_AVAIL = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_WIDTH:0] r_waddr;
    logic [ADDR_WIDTH:0] r_raddr;
    logic [ADDR_WIDTH:0] r_word_count;
    logic [7:0]          r_data_valid;
    logic                r_error;
    logic [63:0]         r_rd_data;
    logic [63:0]         r_mem [DEPTH];

    logic w_rst;
    logic w_wr_accept;
    logic w_overflow;
    logic w_wr_in_avail;
    logic w_discard;
    logic w_rd_accept;

    // Clear behaves exactly like reset and overrides every other input.
    assign w_rst         = i_areset | i_clear;
    assign w_wr_accept   = (r_state == ST_FILL) && i_write_en && (r_waddr != PTR_FULL);
    assign w_overflow    = (r_state == ST_FILL) && i_write_en && (r_waddr == PTR_FULL);
    assign w_wr_in_avail = (r_state == ST_AVAIL) && i_write_en;
    assign w_discard     = (r_state == ST_AVAIL) && i_packet_read_discard;
    // A discard in the same cycle as a read request suppresses the read.
    assign w_rd_accept   = (r_state == ST_AVAIL) && i_fifo_rd_en && !i_packet_read_discard
                           && (r_raddr != r_word_count);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge i_clk) begin
        if (w_rst) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_FILL: begin
                if (w_overflow) begin
                    w_state_next = ST_ERROR;
                end else if (w_wr_accept && i_write_last) begin
                    w_state_next = ST_AVAIL;
                end
            end
            ST_AVAIL: begin
                if (w_discard) begin
                    w_state_next = ST_FILL;
                end
            end
            ST_ERROR: begin
                // Only reset or clear leaves this state.
                w_state_next = ST_ERROR;
            end
            default: begin
                w_state_next = ST_FILL;
            end
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // All outputs are functions of registers only, so they change one cycle
    // after the event that caused them.
    always_comb begin
        o_packet_available = (r_state == ST_AVAIL);
        o_busy             = (r_state != ST_FILL) || (r_waddr != PTR_ZERO);
        o_fifo_empty       = (r_state != ST_AVAIL) || (r_raddr == r_word_count);
        o_data_valid       = r_data_valid;
        o_error            = r_error;
        o_fifo_rd_data     = r_rd_data;
    end

    // ---------------- Pointers, mask and error flag ----------------
    always_ff @(posedge i_clk) begin
        if (w_rst) begin
            r_waddr      <= PTR_ZERO;
            r_raddr      <= PTR_ZERO;
            r_word_count <= PTR_ZERO;
            r_data_valid <= 8'h00;
            r_error      <= 1'b0;
        end else begin
            if (w_wr_accept) begin
                r_waddr <= r_waddr + PTR_ONE;
                if (i_write_last) begin
                    r_word_count <= r_waddr + PTR_ONE;
                    r_data_valid <= i_last_word_data_valid;
                end
            end
            if (w_overflow || w_wr_in_avail) begin
                r_error <= 1'b1;
            end
            if (w_rd_accept) begin
                r_raddr <= r_raddr + PTR_ONE;
            end
            if (w_discard) begin
                r_waddr      <= PTR_ZERO;
                r_raddr      <= PTR_ZERO;
                r_word_count <= PTR_ZERO;
                r_data_valid <= 8'h00;
            end
        end
    end

    // ---------------- Packet storage ----------------
    // Contents are never cleared; only the pointers are.
    always_ff @(posedge i_clk) begin
        if (w_wr_accept && !w_rst) begin
            r_mem[r_waddr[ADDR_WIDTH-1:0]] <= i_write_data;
        end
    end

    // Registered read port; holds its value when no read is accepted.
    always_ff @(posedge i_clk) begin
        if (w_rst) begin
            r_rd_data <= 64'h0;
        end else if (w_rd_accept) begin
            r_rd_data <= r_mem[r_raddr[ADDR_WIDTH-1:0]];
        end
    end

endmodule

// File: tb/tb_nts_tx_buffer.sv
module tb_nts_tx_buffer;

    logic        clk;
    logic        areset;
    logic        clear;
    logic        busy;
    logic        error;
    logic        wr_en;
    logic [63:0] wr_data;
    logic        wr_last;
    logic [7:0]  wr_mask;
    logic        pkt_avail;
    logic        discard;
    logic [7:0]  data_valid;
    logic        fifo_empty;
    logic        rd_en;
    logic [63:0] rd_data;

    int total = 0;
    int bad   = 0;

    // Small buffer (4 words) so the full / overflow boundary is reachable.
    nts_tx_buffer #(.ADDR_WIDTH(2)) dut (
        .i_clk                  (clk),
        .i_areset               (areset),
        .i_clear                (clear),
        .o_busy                 (busy),
        .o_error                (error),
        .i_write_en             (wr_en),
        .i_write_data           (wr_data),
        .i_write_last           (wr_last),
        .i_last_word_data_valid (wr_mask),
        .o_packet_available     (pkt_avail),
        .i_packet_read_discard  (discard),
        .o_data_valid           (data_valid),
        .o_fifo_empty           (fifo_empty),
        .i_fifo_rd_en           (rd_en),
        .o_fifo_rd_data         (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 time unit
    // after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [63:0] d, input logic last, input logic [7:0] m);
        wr_en = 1'b1; wr_data = d; wr_last = last; wr_mask = m;
        step();
        wr_en = 1'b0; wr_last = 1'b0; wr_mask = 8'h00;
        $display("write data=%h last=%0b", d, last);
    endtask

    task automatic rd();
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        $display("read  data=%h empty=%0b", rd_data, fifo_empty);
    endtask

    task automatic do_discard();
        discard = 1'b1;
        step();
        discard = 1'b0;
        $display("discard avail=%0b", pkt_avail);
    endtask

    task automatic check_reset_values(input string tag);
        total++;
        if ({busy, error, pkt_avail, data_valid, fifo_empty, rd_data} !==
            {1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 64'h0}) begin
            bad++;
            $display("FAIL %s: busy=%b err=%b avail=%b dv=%h empty=%b rd=%h want 0 0 0 00 1 0",
                     tag, busy, error, pkt_avail, data_valid, fifo_empty, rd_data);
        end
    endtask

    task automatic test_reset();
        areset = 1'b1;
        step(); step();
        areset = 1'b0;
        check_reset_values("reset");
    endtask

    task automatic test_basic();
        wr(64'h1111111111111111, 1'b0, 8'h00);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy: got %b want 1", busy); end
        total++;
        if (pkt_avail !== 1'b0) begin bad++; $display("FAIL basic_avail_early: got %b want 0", pkt_avail); end
        wr(64'h2222222222222222, 1'b0, 8'h00);
        wr(64'h3333333333333333, 1'b1, 8'hf0);
        total++;
        if (pkt_avail !== 1'b1) begin bad++; $display("FAIL basic_avail: got %b want 1", pkt_avail); end
        total++;
        if (data_valid !== 8'hf0) begin bad++; $display("FAIL basic_dv: got %h want f0", data_valid); end
        total++;
        if (fifo_empty !== 1'b0) begin bad++; $display("FAIL basic_empty0: got %b want 0", fifo_empty); end
        rd();
        total++;
        if (rd_data !== 64'h1111111111111111) begin bad++; $display("FAIL basic_rd0: got %h want 1111111111111111", rd_data); end
        rd();
        total++;
        if (rd_data !== 64'h2222222222222222) begin bad++; $display("FAIL basic_rd1: got %h want 2222222222222222", rd_data); end
        total++;
        if (fifo_empty !== 1'b0) begin bad++; $display("FAIL basic_empty_mid: got %b want 0", fifo_empty); end
        rd();
        total++;
        if (rd_data !== 64'h3333333333333333) begin bad++; $display("FAIL basic_rd2: got %h want 3333333333333333", rd_data); end
        total++;
        if (fifo_empty !== 1'b1) begin bad++; $display("FAIL basic_empty_end: got %b want 1", fifo_empty); end
        do_discard();
        total++;
        if ({pkt_avail, busy, fifo_empty, data_valid} !== {1'b0, 1'b0, 1'b1, 8'h00}) begin
            bad++;
            $display("FAIL basic_discard: avail=%b busy=%b empty=%b dv=%h want 0 0 1 00",
                     pkt_avail, busy, fifo_empty, data_valid);
        end
    endtask

    task automatic test_full_and_overflow();
        // Exactly fills the 4-word buffer: legal.
        wr(64'hA0, 1'b0, 8'h00);
        wr(64'hA1, 1'b0, 8'h00);
        wr(64'hA2, 1'b0, 8'h00);
        wr(64'hA3, 1'b1, 8'hff);
        total++;
        if ({pkt_avail, error} !== 2'b10) begin
            bad++; $display("FAIL full_exact: avail=%b err=%b want 1 0", pkt_avail, error);
        end
        do_discard();
        // Fifth word overflows.
        wr(64'hB0, 1'b0, 8'h00);
        wr(64'hB1, 1'b0, 8'h00);
        wr(64'hB2, 1'b0, 8'h00);
        wr(64'hB3, 1'b0, 8'h00);
        total++;
        if (error !== 1'b0) begin bad++; $display("FAIL full_noerr: got %b want 0", error); end
        wr(64'hB4, 1'b1, 8'hff);
        total++;
        if ({error, pkt_avail, busy} !== 3'b101) begin
            bad++; $display("FAIL overflow: err=%b avail=%b busy=%b want 1 0 1", error, pkt_avail, busy);
        end
        // Discard is ignored in the error state.
        do_discard();
        total++;
        if ({error, busy} !== 2'b11) begin
            bad++; $display("FAIL err_discard: err=%b busy=%b want 1 1", error, busy);
        end
        clear = 1'b1;
        step();
        clear = 1'b0;
        check_reset_values("clear_after_error");
    endtask

    task automatic test_discard_with_read();
        wr(64'hC0C0C0C0C0C0C0C0, 1'b0, 8'h00);
        wr(64'hC1C1C1C1C1C1C1C1, 1'b0, 8'h00);
        wr(64'hC2C2C2C2C2C2C2C2, 1'b1, 8'hff);
        rd();
        total++;
        if (rd_data !== 64'hC0C0C0C0C0C0C0C0) begin bad++; $display("FAIL disc_rd0: got %h want c0c0c0c0c0c0c0c0", rd_data); end
        rd_en = 1'b1;
        do_discard();
        rd_en = 1'b0;
        total++;
        if (rd_data !== 64'hC0C0C0C0C0C0C0C0) begin bad++; $display("FAIL disc_noread: got %h want c0c0c0c0c0c0c0c0", rd_data); end
        total++;
        if ({pkt_avail, fifo_empty, busy} !== 3'b010) begin
            bad++; $display("FAIL disc_state: avail=%b empty=%b busy=%b want 0 1 0", pkt_avail, fifo_empty, busy);
        end
        wr(64'hD0D0D0D0D0D0D0D0, 1'b0, 8'h00);
        wr(64'hD1D1D1D1D1D1D1D1, 1'b1, 8'hc0);
        total++;
        if (data_valid !== 8'hc0) begin bad++; $display("FAIL disc_new_dv: got %h want c0", data_valid); end
        rd();
        total++;
        if (rd_data !== 64'hD0D0D0D0D0D0D0D0) begin bad++; $display("FAIL disc_new_rd0: got %h want d0d0d0d0d0d0d0d0", rd_data); end
        rd();
        total++;
        if (rd_data !== 64'hD1D1D1D1D1D1D1D1) begin bad++; $display("FAIL disc_new_rd1: got %h want d1d1d1d1d1d1d1d1", rd_data); end
        do_discard();
    endtask

    task automatic test_write_in_avail();
        wr(64'hE0E0E0E0E0E0E0E0, 1'b0, 8'h00);
        wr(64'hE1E1E1E1E1E1E1E1, 1'b1, 8'hff);
        wr(64'hBADBADBADBADBADB, 1'b1, 8'h80);
        total++;
        if ({error, pkt_avail, data_valid} !== {1'b1, 1'b1, 8'hff}) begin
            bad++; $display("FAIL wavail_err: err=%b avail=%b dv=%h want 1 1 ff", error, pkt_avail, data_valid);
        end
        rd();
        total++;
        if (rd_data !== 64'hE0E0E0E0E0E0E0E0) begin bad++; $display("FAIL wavail_rd0: got %h want e0e0e0e0e0e0e0e0", rd_data); end
        rd();
        total++;
        if (rd_data !== 64'hE1E1E1E1E1E1E1E1) begin bad++; $display("FAIL wavail_rd1: got %h want e1e1e1e1e1e1e1e1", rd_data); end
        rd();
        total++;
        if ({rd_data, fifo_empty} !== {64'hE1E1E1E1E1E1E1E1, 1'b1}) begin
            bad++; $display("FAIL wavail_extra_rd: data=%h empty=%b want e1e1e1e1e1e1e1e1 1", rd_data, fifo_empty);
        end
        do_discard();
        total++;
        if (error !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b want 1", error); end
        clear = 1'b1;
        step();
        clear = 1'b0;
        check_reset_values("clear_after_wavail");
    endtask

    task automatic test_reset_mid_write();
        // Leave non-zero read data behind so its reset is visible.
        wr(64'h0102030405060708, 1'b1, 8'hff);
        rd();
        do_discard();
        wr(64'hF0F0F0F0F0F0F0F0, 1'b0, 8'h00);
        wr(64'hF1F1F1F1F1F1F1F1, 1'b0, 8'h00);
        areset = 1'b1;
        step();
        areset = 1'b0;
        check_reset_values("reset_mid_write");
        wr(64'h5555555555555555, 1'b0, 8'h00);
        wr(64'h6666666666666666, 1'b1, 8'hfe);
        rd();
        total++;
        if (rd_data !== 64'h5555555555555555) begin bad++; $display("FAIL rst_new_rd0: got %h want 5555555555555555", rd_data); end
        rd();
        total++;
        if ({rd_data, data_valid} !== {64'h6666666666666666, 8'hfe}) begin
            bad++; $display("FAIL rst_new_rd1: data=%h dv=%h want 6666666666666666 fe", rd_data, data_valid);
        end
        do_discard();
    endtask

    task automatic test_single_word();
        wr(64'h7777777777777777, 1'b1, 8'h80);
        total++;
        if ({pkt_avail, fifo_empty, data_valid} !== {1'b1, 1'b0, 8'h80}) begin
            bad++; $display("FAIL single_avail: avail=%b empty=%b dv=%h want 1 0 80", pkt_avail, fifo_empty, data_valid);
        end
        rd();
        total++;
        if ({rd_data, fifo_empty} !== {64'h7777777777777777, 1'b1}) begin
            bad++; $display("FAIL single_rd: data=%h empty=%b want 7777777777777777 1", rd_data, fifo_empty);
        end
        do_discard();
        total++;
        if ({pkt_avail, busy, data_valid, error} !== {1'b0, 1'b0, 8'h00, 1'b0}) begin
            bad++; $display("FAIL single_discard: avail=%b busy=%b dv=%h err=%b want 0 0 00 0",
                            pkt_avail, busy, data_valid, error);
        end
    endtask

    initial begin
        areset = 1'b0; clear = 1'b0; wr_en = 1'b0; wr_data = 64'h0; wr_last = 1'b0;
        wr_mask = 8'h00; discard = 1'b0; rd_en = 1'b0;
        test_reset();
        test_basic();
        test_full_and_overflow();
        test_discard_with_read();
        test_write_in_avail();
        test_reset_mid_write();
        test_single_word();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nts_tx_buffer.md
Name: nts_tx_buffer

Overview:
- Single-packet transmit buffer on the outbound side of the NTS engine.
- The engine's response builder writes a packet as 64-bit words.
- The block then presents the packet to the transmit MAC/dispatcher with the same handshake the dispatcher uses toward the engine: packet_available, fifo_empty, rd_en/rd_data, last-word data_valid, read_discard.

Parameters:
ADDR_WIDTH, 10, log2 of buffer depth in 64-bit words (depth 2^ADDR_WIDTH).

Ports:
i_clk  input  1  clock, all logic on rising edge
i_areset  input  1  reset, synchronous, active-high
i_clear  input  1  synchronous clear of packet state, same effect as reset
o_busy  output  1  packet being written or awaiting readout
o_error  output  1  sticky protocol/overflow error
i_write_en  input  1  write i_write_data to next buffer word
i_write_data  input  64  packet word, byte 0 in bits 63:56
i_write_last  input  1  qualifies current write as final word (sampled only with i_write_en)
i_last_word_data_valid  input  8  byte-valid mask of final word, MSB = byte 0 (8'hff full, 8'h80 one byte)
o_packet_available  output  1  complete packet held for readout
i_packet_read_discard  input  1  reader done; release packet
o_data_valid  output  8  latched last-word mask; 0 when no packet
o_fifo_empty  output  1  all words of current packet read
i_fifo_rd_en  input  1  read request
o_fifo_rd_data  output  64  read data, one cycle after accepted rd_en

Behaviour:
- Reset and i_clear values: state FILL, waddr=0, raddr=0, word_count=0, o_busy=0, o_error=0, o_packet_available=0, o_data_valid=0, o_fifo_empty=1, o_fifo_rd_data=0.
- Memory contents are not cleared. i_clear has priority over all other inputs.
- Pointers and word_count are ADDR_WIDTH+1 bits wide.
- FILL state:
  - Each i_write_en cycle writes mem[waddr] and increments waddr; o_busy rises the cycle after the first write.
  - A write with i_write_last also latches the mask into o_data_valid, sets word_count=waddr+1, and moves to AVAILABLE.
  - A write when waddr==2^ADDR_WIDTH (buffer full) goes to ERROR and sets o_error; the word is dropped.
  - A final word fitting exactly in the last location is legal.
- AVAILABLE state:
  - o_packet_available=1; o_fifo_empty=(raddr==word_count), registered.
  - i_fifo_rd_en with !o_fifo_empty: o_fifo_rd_data<=mem[raddr] next cycle, raddr++.
  - i_fifo_rd_en with o_fifo_empty: ignored; rd_data and raddr hold.
  - i_write_en: word dropped, o_error set, packet retained.
  - i_packet_read_discard: next cycle returns to FILL with pointers and word_count zeroed; o_packet_available=0, o_data_valid=0, o_fifo_empty=1, o_busy=0.
  - Discard is legal before all words are read.
  - Discard and rd_en in the same cycle: discard wins, no read performed.
- ERROR state:
  - o_busy=1, o_packet_available=0; writes ignored; discard ignored.
  - Exit only via i_clear or i_areset.
- i_packet_read_discard or i_fifo_rd_en in FILL: ignored.
- Reset or clear mid-write or mid-read: partial packet abandoned, all outputs take reset values next cycle.
- o_error is sticky until reset/clear.
- Minimum packet is one word; no zero-length packets.

Test Plan:
- 3 writes (0x1111…, 0x2222…, 0x3333… last, mask 8'hf0) → o_packet_available=1 the cycle after last; 3 rd_en pulses return the words in order, 1 cycle latency; o_fifo_empty=1 after the third; o_data_valid=8'hf0.
- ADDR_WIDTH=2: 4 writes, 4th with last → AVAILABLE, no error. Repeat with a 5th write → ERROR, o_error=1, o_packet_available=0; i_clear → FILL with all outputs at reset values.
- AVAILABLE, read 1 of 3 words, then i_packet_read_discard together with i_fifo_rd_en → no read; next cycle o_packet_available=0, o_fifo_empty=1, o_busy=0; a new 2-word packet then reads back correctly from word 0.
- i_write_en during AVAILABLE → o_error=1; buffered packet still reads back unchanged; extra rd_en after empty leaves o_fifo_rd_data holding the last word.
- Assert i_areset mid-write (after 2 words) → all outputs at reset values next cycle; the following packet is unaffected.
- Single-word packet with mask 8'h80 → available, one rd_en, empty; discard → back to FILL.
